data_memory: RTL and testbench

- Parametrised, synchronous data memory for the LEGv8 CPU datapath; the next generation of the single-cycle combinational RAM.
- Adds byte, half, word and doubleword accesses with sign/zero extension (LDUR/LDURB/LDURH/LDURSW, STUR/STURB/STURH/STURW).
- Adds a valid/ready request handshake, registered responses, and alignment/range error reporting.
- Sub-doubleword stores use an internal read-modify-write state machine.

---
 rtl/data_memory.sv | 174 +++++++++++++++++
 tb/tb_data_memory.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Synchronous LEGv8 data memory with byte/half/word/doubleword access, valid/ready
// request handshake, registered response and read-modify-write sub-word stores.
module data_memory #(
   parameter int DATA_WIDTH   = 64,
   parameter int DEPTH        = 32,
   parameter int INIT_PATTERN = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [63:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_error
);

   // state | meaning
   // IDLE  | ready for a request; array read or full store happens at accept
   // READ  | old word available: extract load result, or merge store lane
   // RMW   | write merged word back for a sub-doubleword store
   // RESP  | one-cycle response pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE, READ, RMW, RESP} state_t;

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int IDX_HI = IDX_W + 2;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [IDX_HI:0]         addr_r;
   logic [1:0]              size_r;
   logic                    signed_r;
   logic                    rmw_r;
   logic [DATA_WIDTH-1:0]   wdata_r;
   logic [DATA_WIDTH-1:0]   merge_r;

   logic                    mis_err;
   logic                    range_err;
   logic                    req_err;
   logic                    accept;
   logic                    full_store;
   logic                    mem_we;
   logic                    rd_en;
   logic [IDX_W-1:0]        mem_widx;
   logic [IDX_W-1:0]        mem_ridx;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [5:0]              shamt;
   logic [DATA_WIDTH-1:0]   shifted;
   logic [DATA_WIDTH-1:0]   lmask;
   logic [DATA_WIDTH-1:0]   load_val;
   logic [DATA_WIDTH-1:0]   merged;

   // Storage holds each word XORed with its initial value, so zero-powered RAM
   // reads back as the init pattern without any initialisation pass.
   function automatic logic [DATA_WIDTH-1:0] pat(input logic [IDX_W-1:0] idx);
      if (INIT_PATTERN != 0)
         return DATA_WIDTH'(idx) * DATA_WIDTH'(100);
      else
         return '0;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return DATA_WIDTH'(64'h0000_0000_0000_00FF);
         2'd1:    return DATA_WIDTH'(64'h0000_0000_0000_FFFF);
         2'd2:    return DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
         default: return '1;
      endcase
   endfunction

   always_comb begin
      case (req_size)
         2'd0:    mis_err = 1'b0;
         2'd1:    mis_err = req_addr[0];
         2'd2:    mis_err = |req_addr[1:0];
         default: mis_err = |req_addr[2:0];
      endcase
   end

   assign range_err  = |req_addr[63:IDX_HI+1];
   assign req_err    = mis_err | range_err;
   assign accept     = (state == IDLE) && req_valid && !reset;
   assign full_store = req_write && (req_size == 2'd3);

   assign mem_we    = (accept && !req_err && full_store) || ((state == RMW) && !reset);
   assign rd_en     = accept && !req_err && !full_store;
   assign mem_widx  = (state == RMW) ? addr_r[IDX_HI:3] : req_addr[IDX_HI:3];
   assign mem_ridx  = req_addr[IDX_HI:3];
   assign mem_wdata = (state == RMW) ? merge_r : req_wdata;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_widx] <= mem_wdata ^ pat(mem_widx);
      if (rd_en)
         rd_word <= mem[mem_ridx] ^ pat(mem_ridx);
   end

   assign shamt   = {addr_r[2:0], 3'b000};
   assign shifted = rd_word >> shamt;
   assign lmask   = size_mask(size_r) << shamt;
   assign merged  = (rd_word & ~lmask) | ((wdata_r & size_mask(size_r)) << shamt);

   always_comb begin
      case (size_r)
         2'd0:    load_val = {{56{signed_r & shifted[7]}},  shifted[7:0]};
         2'd1:    load_val = {{48{signed_r & shifted[15]}}, shifted[15:0]};
         2'd2:    load_val = {{32{signed_r & shifted[31]}}, shifted[31:0]};
         default: load_val = rd_word;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_error <= 1'b0;
         addr_r     <= '0;
         size_r     <= '0;
         signed_r   <= 1'b0;
         rmw_r      <= 1'b0;
         wdata_r    <= '0;
         merge_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready  <= 1'b0;
                  resp_rdata <= '0;
                  resp_error <= req_err;
                  addr_r     <= req_addr[IDX_HI:0];
                  size_r     <= req_size;
                  signed_r   <= req_signed;
                  wdata_r    <= req_wdata;
                  rmw_r      <= req_write;
                  if (req_err || full_store) begin
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (rmw_r) begin
                  merge_r <= merged;
                  state   <= RMW;
               end else begin
                  resp_rdata <= load_val;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RMW: begin
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            default: begin
               resp_valid <= 1'b0;
               resp_error <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: loads/stores of every size,
// extension, error paths, reset during RMW and back-to-back handshake.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_error;

   int n_assert = 0;
   int n_fail   = 0;

   data_memory #(.DATA_WIDTH(64), .DEPTH(32), .INIT_PATTERN(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after the accept edge; returns cycles until resp_valid (0 = timeout).
   task automatic wait_resp(input string tag, output int lat);
      lat = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = n;
            break;
         end
         chk({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
      end
   endtask

   task automatic do_op(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_er, input int exp_lat);
      int lat;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      chk({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      // Scramble inputs after accept; the captured request must be used.
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = ~sz;
      req_signed = ~sg;
      req_addr   = ~a;
      req_wdata  = ~wd;
      wait_resp(tag, lat);
      chk({tag, "_lat"},   64'(lat), 64'(exp_lat));
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_error"}, 64'(resp_error), 64'(exp_er));
      chk({tag, "_resp_ready"}, 64'(req_ready), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse_end"}, 64'(resp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      #1 reset = 1'b1;
      #1;
      chk("rst_ready", 64'(req_ready),  64'd1);
      chk("rst_valid", 64'(resp_valid), 64'd0);
      chk("rst_rdata", resp_rdata,      64'd0);
      chk("rst_error", 64'(resp_error), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      do_op("init_rd",  1'b0, 2'd3, 1'b0, 64'h28, 64'h0, 64'd500, 1'b0, 2);
      do_op("st_full",  1'b1, 2'd3, 1'b0, 64'h08, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 1);
      do_op("ld_full",  1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 2);
      do_op("st_byte",  1'b1, 2'd0, 1'b0, 64'h0B, 64'h55AA, 64'd0, 1'b0, 3);
      do_op("ld_after_b", 1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'hDEADBEEF_AAFEF00D, 1'b0, 2);
      do_op("ldb_s",    1'b0, 2'd0, 1'b1, 64'h0B, 64'h0, 64'hFFFFFFFF_FFFFFFAA, 1'b0, 2);
      do_op("ldb_u",    1'b0, 2'd0, 1'b0, 64'h0B, 64'h0, 64'h00000000_000000AA, 1'b0, 2);
      do_op("ldb_s_pos", 1'b0, 2'd0, 1'b1, 64'h08, 64'h0, 64'h00000000_0000000D, 1'b0, 2);
      do_op("ldw_s",    1'b0, 2'd2, 1'b1, 64'h0C, 64'h0, 64'hFFFFFFFF_DEADBEEF, 1'b0, 2);
      do_op("ldw_u",    1'b0, 2'd2, 1'b0, 64'h0C, 64'h0, 64'h00000000_DEADBEEF, 1'b0, 2);
      do_op("st_half",  1'b1, 2'd1, 1'b0, 64'h0E, 64'hFFFF_1234, 64'd0, 1'b0, 3);
      do_op("ld_after_h", 1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h1234BEEF_AAFEF00D, 1'b0, 2);
      do_op("ldh_s_neg", 1'b0, 2'd1, 1'b1, 64'h0A, 64'h0, 64'hFFFFFFFF_FFFFAAFE, 1'b0, 2);
      do_op("ldh_s_pos", 1'b0, 2'd1, 1'b1, 64'h0E, 64'h0, 64'h00000000_00001234, 1'b0, 2);
      do_op("st_word",  1'b1, 2'd2, 1'b0, 64'h1C, 64'hFFFFFFFF_87654321, 64'd0, 1'b0, 3);
      do_op("ld_after_w", 1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h87654321_0000012C, 1'b0, 2);

      do_op("err_misld", 1'b0, 2'd2, 1'b1, 64'h06, 64'h0, 64'd0, 1'b1, 1);
      do_op("err_range", 1'b1, 2'd3, 1'b0, 64'h100, 64'h1111, 64'd0, 1'b1, 1);
      do_op("chk_w0",    1'b0, 2'd3, 1'b0, 64'h00, 64'h0, 64'd0, 1'b0, 2);
      do_op("err_misst", 1'b1, 2'd1, 1'b0, 64'h09, 64'hFFFF, 64'd0, 1'b1, 1);
      do_op("chk_w1",    1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h1234BEEF_AAFEF00D, 1'b0, 2);

      // Reset while the half store to 0x10 sits in RMW.
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_size   = 2'd1;
      req_signed = 1'b0;
      req_addr   = 64'h10;
      req_wdata  = 64'hBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_rd_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rmw_rst_ready", 64'(req_ready),  64'd1);
      chk("rmw_rst_valid", 64'(resp_valid), 64'd0);
      chk("rmw_rst_rdata", resp_rdata,      64'd0);
      chk("rmw_rst_error", 64'(resp_error), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      do_op("rmw_abort", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'd200, 1'b0, 2);

      // Back-to-back: req_valid held high across two loads.
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_size   = 2'd3;
      req_signed = 1'b0;
      req_addr   = 64'h28;
      @(posedge clk);
      #1 req_addr = 64'h30;
      wait_resp("b2b_a", lat);
      chk("b2b_a_lat",   64'(lat), 64'd2);
      chk("b2b_a_rdata", resp_rdata, 64'd500);
      @(negedge clk);
      chk("b2b_gap_valid", 64'(resp_valid), 64'd0);
      chk("b2b_gap_ready", 64'(req_ready),  64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_resp("b2b_b", lat);
      chk("b2b_b_lat",   64'(lat), 64'd2);
      chk("b2b_b_rdata", resp_rdata, 64'd600);
      @(negedge clk);
      chk("b2b_end_ready", 64'(req_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
